// File: rtl/long_mul_unit.sv
// Iterative radix-2 multiply / multiply-accumulate unit feeding the register file write ports.
// One op takes 35 cycles from acceptance to return to IDLE; results leave as a single WB pulse.
module long_mul_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] acc_lo,
  input  logic [31:0] acc_hi,
  input  logic [3:0]  rd_lo,
  input  logic [3:0]  rd_hi,
  output logic        busy,
  output logic        done,
  output logic        we3,
  output logic        long_we,
  output logic [3:0]  a3,
  output logic [3:0]  a4,
  output logic [31:0] wd3,
  output logic [31:0] wd4
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] prod_q, prod_d;
  logic [4:0]  count_q, count_d;
  logic        neg_q, neg_d;
  logic [3:0]  rd_lo_q, rd_lo_d;
  logic [3:0]  rd_hi_q, rd_hi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        we3_q, we3_d;
  logic        long_we_q, long_we_d;
  logic [3:0]  a3_q, a3_d;
  logic [3:0]  a4_q, a4_d;
  logic [31:0] wd3_q, wd3_d;
  logic [31:0] wd4_q, wd4_d;
  logic [63:0] fix_result;
  logic        short_op;
  logic        long_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      acc_q     <= 64'd0;
      prod_q    <= 64'd0;
      count_q   <= 5'd0;
      neg_q     <= 1'b0;
      rd_lo_q   <= 4'd0;
      rd_hi_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we3_q     <= 1'b0;
      long_we_q <= 1'b0;
      a3_q      <= 4'd0;
      a4_q      <= 4'd0;
      wd3_q     <= 32'd0;
      wd4_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      rd_lo_q   <= rd_lo_d;
      rd_hi_q   <= rd_hi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we3_q     <= we3_d;
      long_we_q <= long_we_d;
      a3_q      <= a3_d;
      a4_q      <= a4_d;
      wd3_q     <= wd3_d;
      wd4_q     <= wd4_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (count_q == 5'd31) state_d = FIX;
      FIX:     state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Signed ops multiply magnitudes; the sign is restored in FIX before accumulating.
  always_comb begin
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    count_d  = count_q;
    neg_d    = neg_q;
    rd_lo_d  = rd_lo_q;
    rd_hi_d  = rd_hi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          rd_lo_d = rd_lo;
          rd_hi_d = rd_hi;
          prod_d  = 64'd0;
          count_d = 5'd0;
          if (op[2:1] == 2'b11) begin
            mcand_d  = a[31] ? (~a + 32'd1) : a;
            mplier_d = b[31] ? (~b + 32'd1) : b;
            neg_d    = a[31] ^ b[31];
          end else begin
            mcand_d  = a;
            mplier_d = b;
            neg_d    = 1'b0;
          end
          if (op == 3'b001)
            acc_d = {32'd0, acc_lo};
          else if (op[2] && op[0])
            acc_d = {acc_hi, acc_lo};
          else
            acc_d = 64'd0;
        end
      end
      CALC: begin
        if (mplier_q[count_q])
          prod_d = prod_q + ({32'd0, mcand_q} << count_q);
        count_d = count_q + 5'd1;
      end
      FIX:     prod_d = fix_result;
      default: ;
    endcase
  end

  always_comb begin
    fix_result = (neg_q ? (~prod_q + 64'd1) : prod_q) + acc_q;
    short_op   = (op_q[2:1] == 2'b00);
    long_op    = op_q[2];
  end

  // Outputs are registered, so the WB values are computed while FIX is current.
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == FIX);
    we3_d     = 1'b0;
    long_we_d = 1'b0;
    a3_d      = a3_q;
    a4_d      = a4_q;
    wd3_d     = wd3_q;
    wd4_d     = wd4_q;
    if (state_q == FIX) begin
      we3_d     = short_op && (rd_lo_q != 4'd15);
      long_we_d = long_op && (rd_lo_q != 4'd15) && (rd_hi_q != 4'd15);
      a3_d      = rd_lo_q;
      wd3_d     = fix_result[31:0];
      if (long_op) begin
        a4_d  = rd_hi_q;
        wd4_d = fix_result[63:32];
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign we3     = we3_q;
  assign long_we = long_we_q;
  assign a3      = a3_q;
  assign a4      = a4_q;
  assign wd3     = wd3_q;
  assign wd4     = wd4_q;

endmodule
